squeeze_ctrl: RTL and testbench
===============================

# squeeze_ctrl

Sequencer for the squeeze phase of the Keccak engine. After absorption completes, it steps the squeeze unit's byte counter across the rate portion of the state and presents each 256-bit window as an AXI-Stream-style beat. It requests a Keccak-f permutation whenever the rate block is drained and terminates the stream at the digest length (SHA3) or the requested output length (SHAKE). It sits between the top-level FSM, the permutation core and the output stream port. Output data itself is wired from the squeeze unit's data output at top level; this block drives only control signals.

## Interface
- MAX_OUTPUT_DWIDTH, 256, output beat width in bits (32 bytes per beat)
- RATE_WIDTH, keccak_pkg value, width of rate and byte-counter signals
- LEN_WIDTH, 32, width of output length and total-byte counters

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle pulse; absorption done, begin squeezing (accepted only in IDLE)
- keccak_mode_i  in  MODE_SEL_WIDTH  SHA3_256 / SHA3_512 / SHAKE128 / SHAKE256; latched on start
- rate_i  in  RATE_WIDTH  rate in bits; latched on start
- out_len_i  in  LEN_WIDTH  SHAKE output bytes; 0 = unlimited; latched on start; ignored for SHA3
- stop_i  in  1  abort request
- perm_start_o  out  1  one-cycle pulse requesting a Keccak-f permutation
- perm_done_i  in  1  one-cycle pulse; permutation finished
- bytes_squeezed_o  out  RATE_WIDTH  byte offset within rate; drives the squeeze unit
- m_axis_tvalid_o  out  1  beat valid
- m_axis_tready_i  in  1  sink ready
- m_axis_tkeep_o  out  MAX_OUTPUT_DWIDTH/8  valid-byte mask, LSB-contiguous
- m_axis_tlast_o  out  1  final beat of the digest
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the tlast handshake

## Operation
- Latched values: rate_bytes = rate_q>>3; target = 32 (SHA3_256), 64 (SHA3_512), out_len_q (SHAKE); unlimited = SHAKE && out_len_q==0.
- Counters:
  - off (RATE_WIDTH) drives bytes_squeezed_o.
  - total (LEN_WIDTH+1) counts bytes delivered and never wraps.
- beat_bytes = min(32, rate_bytes-off, unlimited ? 32 : target-total).
- tkeep = beat_bytes==32 ? all ones : (1<<beat_bytes)-1.
- tlast = !unlimited && (total+beat_bytes >= target), compared at LEN_WIDTH+1 bits.
- States:
  - IDLE: all control outputs low. start_i latches the inputs, clears off and total, then goes to OUTPUT.
  - OUTPUT: tvalid=1. On handshake (tvalid&&tready), total += beat_bytes, then:
    - if tlast, go to DONE;
    - else if off+32 >= rate_bytes, clear off and go to PERMUTE;
    - else off += 32.
  - PERMUTE: tvalid=0. perm_start_o high for the first cycle in the state only. perm_done_i returns to OUTPUT.
  - DRAIN: tvalid=0. Waits for perm_done_i, then goes to IDLE. Used only after an abort during PERMUTE.
  - DONE: done_o=1, busy=1 for one cycle, then IDLE.
- stop_i:
  - in OUTPUT or DONE: go to IDLE next cycle; no tlast or done_o is issued.
  - in PERMUTE: go to DRAIN, so the core is never abandoned mid-permutation.
  - in IDLE or DRAIN: ignored.
  - stop_i takes priority over a simultaneous handshake; that beat counts as delivered but causes no state advance.
- start_i outside IDLE is ignored. perm_done_i outside PERMUTE/DRAIN is ignored.
- AXI rule: while tvalid is high and tready is low, tkeep, tlast and bytes_squeezed_o are held stable. The only exception is stop_i.

## Timing
- Reset: state IDLE, off=0, total=0; every output 0.
- Reset asserted mid-operation returns to IDLE on the next edge, with no pending perm_start_o or done_o.
- start_i at cycle 0 gives tvalid high at cycle 1.
- Beats stream back-to-back with zero bubbles while tready is high.
- Handshake on a drained beat at cycle n: perm_start_o at n+1; perm_done_i at cycle m gives tvalid at m+1.
- tlast handshake at cycle n: done_o at n+1; busy_o low and start_i accepted at n+2.

## Test plan
- SHA3_256, rate 1088, tready=1: start -> one beat, tkeep=0xFFFFFFFF, tlast=1, bytes_squeezed_o=0; done_o one cycle later; perm_start_o never asserted.
- SHA3_512, rate 576, tready toggling 1:1 -> two beats, offsets 0 and 32, tlast on the second; outputs stable while stalled.
- SHAKE128, out_len 200 -> beats of 32,32,32,32,32,8 (last tkeep=0xFF); perm_start_o; perm_done_i after 24 cycles -> one beat of 32 at offset 0 with tlast; total=200.
- SHAKE256, out_len 50 -> beats 32 then 18 (tkeep=0x0003FFFF, tlast=1); no permutation.
- SHAKE256, out_len 0 -> continuous 32,32,32,32,8 pattern with periodic perm_start_o and no tlast. stop_i during OUTPUT -> IDLE next cycle. stop_i during PERMUTE -> DRAIN until perm_done_i, then IDLE, done_o never asserted.
- rst_n low mid-OUTPUT with tready=0 -> all outputs 0 next cycle. New start_i -> sequence restarts at offset 0.

Source files
------------

// File: rtl/squeeze_ctrl_if.sv
// Output beat stream of the squeeze sequencer: control side of an AXI-Stream beat.
// Data is wired separately from the squeeze unit, so only valid/ready/keep/last live here.
interface squeeze_ctrl_if #(
  parameter int KEEP_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, tkeep, tlast, input tready);
  modport slave  (input tvalid, tkeep, tlast, output tready);
endinterface

// File: rtl/squeeze_ctrl.sv
// Squeeze-phase sequencer: walks the rate block in 32-byte windows, requests a
// permutation when the block is drained and ends the stream at the output length.
module squeeze_ctrl #(
  parameter int MAX_OUTPUT_DWIDTH = 256,
  parameter int RATE_WIDTH        = 11,
  parameter int LEN_WIDTH         = 32,
  parameter int MODE_SEL_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]     rate_i,
  input  logic [LEN_WIDTH-1:0]      out_len_i,
  input  logic                      stop_i,
  output logic                      perm_start_o,
  input  logic                      perm_done_i,
  output logic [RATE_WIDTH-1:0]     bytes_squeezed_o,
  squeeze_ctrl_if.master            m_axis,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int BEAT_B = MAX_OUTPUT_DWIDTH / 8;
  localparam int BW     = $clog2(BEAT_B + 1);

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(1);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = MODE_SEL_WIDTH'(2);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = MODE_SEL_WIDTH'(3);

  localparam logic [BW-1:0]         BEAT_FULL = BW'(BEAT_B);
  localparam logic [RATE_WIDTH-1:0] BEAT_OFF  = RATE_WIDTH'(BEAT_B);
  localparam logic [RATE_WIDTH:0]   BEAT_R    = (RATE_WIDTH+1)'(BEAT_B);

  typedef enum logic [2:0] {S_IDLE, S_OUTPUT, S_PERMUTE, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [MODE_SEL_WIDTH-1:0] mode_q, mode_d;
  logic [RATE_WIDTH-1:0]     rate_q, rate_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [RATE_WIDTH-1:0]     off_q, off_d;
  logic [LEN_WIDTH:0]        total_q, total_d;
  logic                      perm_req_q, perm_req_d;

  logic [RATE_WIDTH-1:0] rate_bytes;
  logic                  unlimited;
  logic [LEN_WIDTH:0]    target;
  logic [RATE_WIDTH:0]   rate_left;
  logic [LEN_WIDTH:0]    len_left;
  logic [BW-1:0]         beat;
  logic [BEAT_B:0]       keep_ext;
  logic                  last_beat;
  logic                  drained;
  logic                  hs;

  // Beat geometry is a pure function of registered state, so it holds while stalled.
  always_comb begin
    rate_bytes = rate_q >> 3;
    unlimited  = (mode_q == MODE_SHAKE128 || mode_q == MODE_SHAKE256) && (len_q == '0);
    case (mode_q)
      MODE_SHA3_256: target = (LEN_WIDTH+1)'(32);
      MODE_SHA3_512: target = (LEN_WIDTH+1)'(64);
      default:       target = {1'b0, len_q};
    endcase
    rate_left = {1'b0, rate_bytes} - {1'b0, off_q};
    len_left  = target - total_q;
    beat      = BEAT_FULL;
    if (rate_left < BEAT_R) beat = BW'(rate_left);
    if (!unlimited && len_left < (LEN_WIDTH+1)'(beat)) beat = BW'(len_left);
    keep_ext  = ((BEAT_B+1)'(1) << beat) - (BEAT_B+1)'(1);
    last_beat = !unlimited && ((total_q + (LEN_WIDTH+1)'(beat)) >= target);
    drained   = ({1'b0, off_q} + BEAT_R) >= {1'b0, rate_bytes};
    hs        = (state_q == S_OUTPUT) && m_axis.tready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      rate_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      total_q    <= '0;
      perm_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rate_q     <= rate_d;
      len_q      <= len_d;
      off_q      <= off_d;
      total_q    <= total_d;
      perm_req_q <= perm_req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_OUTPUT;
      S_OUTPUT: begin
        if (stop_i)         state_d = S_IDLE;
        else if (hs) begin
          if (last_beat)    state_d = S_DONE;
          else if (drained) state_d = S_PERMUTE;
        end
      end
      // A stop coinciding with perm_done has nothing left to drain.
      S_PERMUTE: begin
        if (perm_done_i) state_d = stop_i ? S_IDLE : S_OUTPUT;
        else if (stop_i) state_d = S_DRAIN;
      end
      S_DRAIN:  if (perm_done_i) state_d = S_IDLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    rate_d     = rate_q;
    len_d      = len_q;
    off_d      = off_q;
    total_d    = total_q;
    perm_req_d = (state_d == S_PERMUTE) && (state_q != S_PERMUTE);
    if (state_q == S_IDLE && start_i) begin
      mode_d  = keccak_mode_i;
      rate_d  = rate_i;
      len_d   = out_len_i;
      off_d   = '0;
      total_d = '0;
    end
    if (hs) begin
      total_d = total_q + (LEN_WIDTH+1)'(beat);
      if (!stop_i && !last_beat) off_d = drained ? '0 : off_q + BEAT_OFF;
    end
    if (state_d == S_IDLE) off_d = '0;
  end

  always_comb begin
    m_axis.tvalid    = (state_q == S_OUTPUT);
    m_axis.tkeep     = m_axis.tvalid ? keep_ext[BEAT_B-1:0] : '0;
    m_axis.tlast     = m_axis.tvalid && last_beat;
    perm_start_o     = (state_q == S_PERMUTE) && perm_req_q;
    bytes_squeezed_o = off_q;
    busy_o           = (state_q != S_IDLE);
    done_o           = (state_q == S_DONE);
  end
endmodule

// File: tb/tb_squeeze_ctrl.sv
// Bench for squeeze_ctrl: directed vector table, random transactions against a
// beat-list reference model, and hand-written stop/reset sequences.
module tb_squeeze_ctrl;
  localparam int RW = 11;
  localparam int LW = 32;
  localparam int KW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, stop_i, perm_done_i;
  logic [1:0]    mode_i;
  logic [RW-1:0] rate_i;
  logic [LW-1:0] out_len_i;
  logic          perm_start_o, busy_o, done_o;
  logic [RW-1:0] bytes_squeezed_o;

  always #5 clk = ~clk;

  squeeze_ctrl_if #(.KEEP_W(KW)) axis ();

  squeeze_ctrl #(.MAX_OUTPUT_DWIDTH(256), .RATE_WIDTH(RW), .LEN_WIDTH(LW), .MODE_SEL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .keccak_mode_i(mode_i), .rate_i(rate_i),
    .out_len_i(out_len_i), .stop_i(stop_i), .perm_start_o(perm_start_o), .perm_done_i(perm_done_i),
    .bytes_squeezed_o(bytes_squeezed_o), .m_axis(axis), .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int off; int nb; bit last; bit drain; } beat_t;
  beat_t mq[$];

  typedef struct { int mode; int rate; int len; int trm; int lat; int ebeats; int eperm; logic [31:0] ekeep; } vec_t;
  vec_t vt[6];
  int   rates[5];
  int   nb, np;
  logic [31:0] lk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] keep_of(input int n);
    logic [32:0] one;
    one = 33'd1;
    return 32'((one << n) - 33'd1);
  endfunction

  // Expected beat list: every beat in delivery order with its offset, size and role.
  function automatic void build(input int mode, input int rate, input int len, input int maxb);
    int rb, tgt, off, tot, n;
    bit unl;
    beat_t b;
    rb  = rate / 8;
    tgt = (mode == 0) ? 32 : (mode == 1) ? 64 : len;
    unl = (mode >= 2) && (len == 0);
    off = 0; tot = 0;
    mq.delete();
    while (mq.size() < maxb) begin
      n = 32;
      if (rb - off < n) n = rb - off;
      if (!unl && tgt - tot < n) n = tgt - tot;
      b.off = off; b.nb = n; b.last = !unl && (tot + n >= tgt); b.drain = (off + 32 >= rb);
      mq.push_back(b);
      tot += n;
      if (b.last) break;
      off = b.drain ? 0 : off + 32;
    end
  endfunction

  // Called and returns at a negedge. ph: 1 expect perm_start, 2 expect done, 3 expect tvalid.
  task automatic run(input int mode, input int rate, input int len, input int trm, input int lat,
                     input int maxb, output int onb, output int onp, output logic [31:0] olk);
    int ph, pcnt;
    bit tog, stall, fin, tr;
    beat_t h;
    logic [31:0] pk;
    logic pl;
    logic [RW-1:0] po;
    build(mode, rate, len, maxb);
    onb = 0; onp = 0; olk = '0; pcnt = 0; tog = 0; stall = 0; fin = 0; pk = '0; pl = 0; po = '0;
    mode_i = 2'(mode); rate_i = RW'(rate); out_len_i = LW'(len); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ph = 3;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      chk("perm_start", perm_start_o, 64'(ph == 1));
      chk("done_pulse", done_o, 64'(ph == 2));
      if (ph == 3) chk("valid_on_time", axis.tvalid, 1);
      if (ph == 2) begin
        chk("busy_in_done", busy_o, 1);
        chk("valid_in_done", axis.tvalid, 0);
        axis.tready = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy_o, 0);
        chk("done_once", done_o, 0);
        fin = 1;
      end else begin
        ph = 0;
        perm_done_i = 1'b0;
        if (pcnt > 0) begin
          pcnt--;
          if (pcnt == 0) begin perm_done_i = 1'b1; ph = 3; end
        end
        if (perm_start_o) begin onp++; pcnt = lat; end
        if (pcnt > 0 || perm_start_o) chk("no_valid_in_perm", axis.tvalid, 0);
        tog = ~tog;
        tr  = (trm == 0) ? 1'b1 : (trm == 1) ? tog : 1'($urandom_range(0, 1));
        if (axis.tvalid) begin
          if (stall) begin
            chk("stall_keep", axis.tkeep, pk);
            chk("stall_last", axis.tlast, pl);
            chk("stall_off", bytes_squeezed_o, po);
          end
          if (tr) begin
            if (mq.size() == 0) chk("extra_beat", axis.tvalid, 0);
            else begin
              h = mq.pop_front();
              chk("beat_off", bytes_squeezed_o, RW'(h.off));
              chk("beat_keep", axis.tkeep, keep_of(h.nb));
              chk("beat_last", axis.tlast, h.last);
              onb++;
              olk = axis.tkeep;
              ph  = h.last ? 2 : h.drain ? 1 : 3;
              if (mq.size() == 0 && !h.last) fin = 1;
            end
            stall = 0;
          end else begin
            stall = 1; pk = axis.tkeep; pl = axis.tlast; po = bytes_squeezed_o;
          end
        end
        axis.tready = tr;
        if (!fin) @(negedge clk);
      end
    end
    chk("timeout", fin, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; perm_done_i = 1'b0;
    mode_i = '0; rate_i = '0; out_len_i = '0; axis.tready = 1'b0;
    vt[0] = '{0, 1088,   0, 0,  4,  1, 0, 32'hFFFFFFFF};
    vt[1] = '{1,  576,   0, 1,  4,  2, 0, 32'hFFFFFFFF};
    vt[2] = '{2, 1344, 200, 0, 24,  7, 1, 32'hFFFFFFFF};
    vt[3] = '{3, 1088,  50, 0,  4,  2, 0, 32'h0003FFFF};
    vt[4] = '{3, 1088, 300, 2,  3, 11, 2, 32'h0FFFFFFF};
    vt[5] = '{2, 1344,   1, 1,  2,  1, 0, 32'h00000001};
    rates = '{576, 832, 1088, 1152, 1344};
    repeat (3) @(negedge clk);
    chk("rst_valid", axis.tvalid, 0);
    chk("rst_keep", axis.tkeep, 0);
    chk("rst_last", axis.tlast, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_perm", perm_start_o, 0);
    chk("rst_off", bytes_squeezed_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(vt[i].mode, vt[i].rate, vt[i].len, vt[i].trm, vt[i].lat, 64, nb, np, lk);
      chk("vec_beats", 64'(nb), 64'(vt[i].ebeats));
      chk("vec_perms", 64'(np), 64'(vt[i].eperm));
      chk("vec_lastkeep", lk, vt[i].ekeep);
      chk("vec_model_empty", 64'(mq.size()), 0);
    end

    for (int i = 0; i < 20; i++) begin
      run($urandom_range(0, 3), rates[$urandom_range(0, 4)], $urandom_range(1, 400), 2,
          $urandom_range(1, 30), 64, nb, np, lk);
      chk("rnd_model_empty", 64'(mq.size()), 0);
    end

    // Unlimited SHAKE256: ten beats (32,32,32,32,8 twice), then stop while permuting.
    run(3, 1088, 0, 0, 2, 10, nb, np, lk);
    chk("unl_perms", 64'(np), 1);
    @(negedge clk);
    chk("unl_perm2", perm_start_o, 1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("drain_busy", busy_o, 1);
    chk("drain_valid", axis.tvalid, 0);
    chk("drain_perm", perm_start_o, 0);
    repeat (3) begin
      @(negedge clk);
      chk("drain_wait", busy_o, 1);
      chk("drain_nodone", done_o, 0);
    end
    perm_done_i = 1'b1;
    @(negedge clk);
    perm_done_i = 1'b0;
    chk("drain_idle", busy_o, 0);
    chk("drain_nodone2", done_o, 0);

    // Stop during OUTPUT.
    run(3, 1088, 0, 0, 2, 3, nb, np, lk);
    @(negedge clk);
    chk("out_valid", axis.tvalid, 1);
    chk("out_off", bytes_squeezed_o, 96);
    chk("out_nolast", axis.tlast, 0);
    stop_i = 1'b1; axis.tready = 1'b0;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_idle", busy_o, 0);
    chk("stop_valid", axis.tvalid, 0);
    chk("stop_done", done_o, 0);
    @(negedge clk);
    chk("stop_done2", done_o, 0);

    // Reset mid-OUTPUT while stalled, then a clean restart.
    mode_i = 2'd1; rate_i = RW'(576); out_len_i = '0; start_i = 1'b1; axis.tready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", axis.tvalid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", axis.tvalid, 0);
    chk("mid_rst_keep", axis.tkeep, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_perm", perm_start_o, 0);
    chk("mid_rst_done", done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(1, 576, 0, 0, 3, 64, nb, np, lk);
    chk("restart_beats", 64'(nb), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
